// File: rtl/mbist_pkg.sv
// MBIST March C- controller shared types.
// States, march element encoding and the March C- table.
package mbist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_CMP,
        S_WRITE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic dir_up;
        logic has_rd;
        logic rd_val;
        logic has_wr;
        logic wr_val;
    } march_elem_t;

    localparam int NUM_ELEM = 6;

    // {dir_up, has_rd, rd_val, has_wr, wr_val} for M0..M5
    localparam march_elem_t MARCH_CM [NUM_ELEM] = '{
        '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
        '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}
    };

endpackage

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: drives the external address counter and
// memory strobes, compares read data, captures the first failure.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_q,
    output logic              cnt_cen,
    output logic              cnt_ld,
    output logic              cnt_ud,
    output logic [ADDR_W-1:0] cnt_d_in,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    state_t              state_q;
    logic [2:0]          elem_q;
    logic                busy_q;
    logic                done_q;
    logic                fail_q;
    logic [ADDR_W-1:0]   fail_addr_q;
    logic [2:0]          fail_elem_q;

    march_elem_t         cur;
    logic                at_term;
    logic                last_elem;
    logic                mismatch;
    logic [DATA_W-1:0]   exp_rd;
    logic [DATA_W-1:0]   wr_data;

    assign cur       = MARCH_CM[elem_q];
    assign at_term   = cur.dir_up ? (&addr_q) : (~|addr_q);
    assign last_elem = (elem_q == 3'(NUM_ELEM - 1));
    assign exp_rd    = {DATA_W{cur.rd_val}};
    assign wr_data   = {DATA_W{cur.wr_val}};
    assign mismatch  = (state_q == S_CMP) && (mem_rdata != exp_rd);

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_elem = fail_elem_q;

    // Counter and memory strobes decoded from the current state.
    always_comb begin
        cnt_cen   = 1'b0;
        cnt_ld    = 1'b0;
        cnt_ud    = 1'b0;
        cnt_d_in  = '0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            S_LOAD: begin
                cnt_cen  = 1'b1;
                cnt_ld   = 1'b1;
                cnt_ud   = cur.dir_up;
                cnt_d_in = cur.dir_up ? '0 : '1;
            end
            S_READ: begin
                mem_cs = 1'b1;
            end
            S_CMP: begin
                mem_cs    = cur.has_wr;
                mem_we    = cur.has_wr;
                mem_wdata = cur.has_wr ? wr_data : '0;
                cnt_cen   = ~at_term;
                cnt_ud    = cur.dir_up;
            end
            S_WRITE: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = wr_data;
                cnt_cen   = ~at_term;
                cnt_ud    = cur.dir_up;
            end
            default: begin
            end
        endcase
    end

    // March sequencing, status flags and first-failure capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LOAD;
                        elem_q      <= '0;
                        busy_q      <= 1'b1;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_elem_q <= '0;
                    end
                end
                S_LOAD: begin
                    state_q <= cur.has_rd ? S_READ : S_WRITE;
                end
                S_READ: begin
                    state_q <= S_CMP;
                end
                S_CMP, S_WRITE: begin
                    if (mismatch && !fail_q) begin
                        fail_q      <= 1'b1;
                        fail_addr_q <= addr_q;
                        fail_elem_q <= elem_q;
                    end
                    if (!at_term) begin
                        state_q <= cur.has_rd ? S_READ : S_WRITE;
                    end else if (last_elem) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_LOAD;
                        elem_q  <= elem_q + 3'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl with a real up/down counter and a
// 1-cycle-latency SRAM that can carry one stuck-at bit.
module tb_mbist_march_ctrl;

    localparam int AW = 2;
    localparam int DW = 8;
    localparam int N  = 1 << AW;
    localparam int T  = 11 * N + 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] addr_q = '0;
    logic          cnt_cen, cnt_ld, cnt_ud;
    logic [AW-1:0] cnt_d_in;
    logic          mem_cs, mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rdata_q = '0;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    int errors = 0;
    int checks = 0;

    bit f_en;
    int f_addr, f_bit;
    bit f_val;
    logic [DW-1:0] mem [N];

    int done_cyc, done_cnt, fail_cyc, busy_bad, cen_ones;
    logic fail1;
    logic [AW-1:0] rd_trace [$];
    logic [AW-1:0] exp_reads [$];
    logic [AW:0]   ld_trace [$];
    logic [AW:0]   exp_loads [$];
    bit exp_fail;
    int exp_faddr, exp_felem, exp_fail_cyc;

    mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .addr_q(addr_q),
        .cnt_cen(cnt_cen), .cnt_ld(cnt_ld), .cnt_ud(cnt_ud),
        .cnt_d_in(cnt_d_in), .mem_cs(mem_cs), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(rdata_q), .busy(busy),
        .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_elem(fail_elem)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v,
                                             input int a);
        logic [DW-1:0] r;
        r = v;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (cnt_cen)
            addr_q <= cnt_ld ? cnt_d_in
                    : (cnt_ud ? addr_q + 1'b1 : addr_q - 1'b1);
    end

    always @(posedge clk) begin
        if (mem_cs && mem_we) mem[addr_q] <= mem_wdata;
        if (mem_cs && !mem_we) rdata_q <= faulty(mem[addr_q], int'(addr_q));
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // March C- run on an array, straight from the element table.
    task automatic model();
        bit up [6]  = '{1, 1, 1, 0, 0, 1};
        bit hrd [6] = '{0, 1, 1, 1, 1, 1};
        bit rv [6]  = '{0, 0, 1, 0, 1, 0};
        bit hwr [6] = '{1, 1, 1, 1, 1, 0};
        bit wv [6]  = '{0, 1, 0, 1, 0, 0};
        logic [DW-1:0] m [N];
        int cyc, a;
        logic [DW-1:0] r;
        for (int i = 0; i < N; i++) m[i] = '0;
        exp_fail = 0; exp_faddr = 0; exp_felem = 0; exp_fail_cyc = 0;
        exp_reads.delete();
        exp_loads.delete();
        cyc = 1;
        for (int e = 0; e < 6; e++) begin
            exp_loads.push_back({up[e] ? 1'b1 : 1'b0,
                                 up[e] ? {AW{1'b0}} : {AW{1'b1}}});
            cyc++;
            for (int k = 0; k < N; k++) begin
                a = up[e] ? k : N - 1 - k;
                if (hrd[e]) begin
                    exp_reads.push_back(AW'(a));
                    r = faulty(m[a], a);
                    if (r != {DW{rv[e]}} && !exp_fail) begin
                        exp_fail = 1;
                        exp_faddr = a;
                        exp_felem = e;
                        exp_fail_cyc = cyc + 2;
                    end
                    cyc += 2;
                end else begin
                    cyc += 1;
                end
                if (hwr[e]) m[a] = {DW{wv[e]}};
            end
        end
    endtask

    task automatic run(input int tog1, input int tog2);
        rd_trace.delete();
        ld_trace.delete();
        done_cyc = 0; done_cnt = 0; fail_cyc = 0;
        busy_bad = 0; cen_ones = 0; fail1 = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= T + 3; cyc++) begin
            if (cyc == 1) fail1 = fail;
            if (busy !== (cyc <= T)) busy_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fail && fail_cyc == 0) fail_cyc = cyc;
            if (mem_cs && !mem_we) rd_trace.push_back(addr_q);
            if (cnt_ld) ld_trace.push_back({cnt_ud, cnt_d_in});
            if (cnt_cen) cen_ones++;
            start = (cyc == tog1) || (cyc == tog2);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic run_checks(input string nm);
        int bad;
        model();
        check({nm, "_done_cyc"}, done_cyc, T);
        check({nm, "_done_cnt"}, done_cnt, 1);
        check({nm, "_busy"}, busy_bad, 0);
        check({nm, "_fail_clr"}, {31'd0, fail1}, 0);
        check({nm, "_fail"}, {31'd0, fail}, {31'd0, exp_fail});
        check({nm, "_faddr"}, fail_addr, exp_faddr);
        check({nm, "_felem"}, fail_elem, exp_felem);
        check({nm, "_fail_cyc"}, fail_cyc, exp_fail_cyc);
        check({nm, "_cen_cnt"}, cen_ones, 6 + 6 * (N - 1));
        check({nm, "_rd_len"}, rd_trace.size(), exp_reads.size());
        bad = 0;
        for (int i = 0; i < rd_trace.size() && i < exp_reads.size(); i++)
            if (rd_trace[i] !== exp_reads[i]) bad++;
        check({nm, "_rd_trace"}, bad, 0);
        check({nm, "_ld_len"}, ld_trace.size(), exp_loads.size());
        bad = 0;
        for (int i = 0; i < ld_trace.size() && i < exp_loads.size(); i++)
            if (ld_trace[i] !== exp_loads[i]) bad++;
        check({nm, "_ld_trace"}, bad, 0);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({cnt_cen, cnt_ld, cnt_ud, cnt_d_in, mem_cs, mem_we,
                    mem_wdata, busy, done, fail, fail_addr, fail_elem});
    endfunction

    initial begin
        logic [DW-1:0] acc;
        int k;
        rst_n = 1'b0;
        start = 1'b0;
        f_en = 0; f_addr = 0; f_bit = 0; f_val = 0;
        for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
        #12;
        check("reset_outs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fault-free, plus M3 load/trace details
        run(0, 0);
        run_checks("clean");
        check("m3_load", ld_trace.size() > 3 ? 32'(ld_trace[3]) : 32'hx,
              32'b011);
        acc = '0;
        for (int i = 0; i < N; i++) acc = acc | mem[i];
        check("mem_zero", acc, 0);

        f_en = 1; f_addr = 2; f_bit = 0; f_val = 1;
        run(0, 0);
        run_checks("sa1_a2b0");
        check("sa1_a2b0_pos", {fail_addr, fail_elem}, {2'd2, 3'd1});

        f_en = 1; f_addr = 3; f_bit = 7; f_val = 0;
        run(0, 0);
        run_checks("sa0_a3b7");
        check("sa0_a3b7_pos", {fail_addr, fail_elem}, {2'd3, 3'd2});

        f_en = 0;
        run(5, 30);
        run_checks("toggle");

        // reset in the middle of a failing run
        f_en = 1; f_addr = 1; f_bit = 3; f_val = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1 check("midrst_a", all_outs(), 0);
        @(negedge clk);
        check("midrst_b", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        f_en = 0;
        run(0, 0);
        run_checks("after_rst");

        for (int it = 0; it < 4; it++) begin
            f_en = bit'($urandom_range(0, 1));
            f_addr = $urandom_range(0, N - 1);
            f_bit = $urandom_range(0, DW - 1);
            f_val = bit'($urandom_range(0, 1));
            run(int'($urandom_range(0, T)), 0);
            run_checks($sformatf("rnd%0d", it));
        end

        // start held high: back-to-back tests
        f_en = 0;
        @(negedge clk);
        start = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 200);
        check("hold_done_cyc", k, T);
        @(negedge clk);
        check("hold_idle_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("hold_reload", {30'd0, busy, cnt_ld}, 2'b11);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- March C- sequencer for the MBIST engine. It drives the address up/down counter (cen/ld/u_d/d_in), consumes the counter's q as the current address, and issues memory chip-select, write-enable and write data.
- It compares read data against the expected background, reports pass/fail and captures the first failing address and march element.
- It sits beside the address counter inside the MBIST top level. The counter's q also drives the memory address bus directly.

Parameters:
- ADDR_W, 10, address width; must equal the address counter length. Depth N = 2**ADDR_W.
- DATA_W, 8, memory word width. Backgrounds are all-zeros and all-ones.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a test; sampled only in IDLE.
- addr_q  in  ADDR_W  current address, from counter q.
- cnt_cen  out  1  counter enable.
- cnt_ld  out  1  counter load.
- cnt_ud  out  1  counter direction: 1 = up, 0 = down.
- cnt_d_in  out  ADDR_W  counter load value.
- mem_cs  out  1  memory access strobe.
- mem_we  out  1  1 = write, 0 = read (valid when mem_cs=1).
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data; valid the cycle after a read strobe.
- busy  out  1  high from the first LOAD until the end of DONE.
- done  out  1  one-cycle pulse at test end.
- fail  out  1  sticky mismatch flag.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_elem  out  3  march element index (0-5) of the first mismatch.

Behaviour:
- Reset (async on rst_n=0): state IDLE. All outputs 0, including fail, fail_addr and fail_elem.
- March table, elements 0..5:
  - M0: up, w0
  - M1: up, r0 w1
  - M2: up, r1 w0
  - M3: down, r0 w1
  - M4: down, r1 w0
  - M5: up, r0
  - "0" = {DATA_W{1'b0}}, "1" = {DATA_W{1'b1}}.
- States: IDLE, LOAD, READ, CMP, WRITE, DONE.
- IDLE: strobes low, busy=0. On start=1, the next state is LOAD with elem=0. fail, fail_addr and fail_elem clear on that same edge.
- LOAD (1 cycle): cnt_cen=1, cnt_ld=1, cnt_ud = element direction, cnt_d_in = 0 (up) or all-ones (down).
  - Next state: WRITE if the element has no read, else READ.
- READ (1 cycle): mem_cs=1, mem_we=0. Next state CMP.
- CMP (1 cycle): compare mem_rdata with the expected value.
  - If the element has a write: mem_cs=1, mem_we=1, mem_wdata = write value, in the same cycle.
- WRITE (1 cycle, M0 only): mem_cs=1, mem_we=1, mem_wdata = write value.
- Address stepping, on the last cycle of each address (CMP, or WRITE for M0):
  - If addr_q != terminal: cnt_cen=1, cnt_ld=0, cnt_ud = direction. Return to READ (or WRITE for M0).
  - Terminal address is all-ones for up, 0 for down.
  - At the terminal address: cnt_cen=0, so there is no wrap. elem increments and the next state is LOAD. After elem 5, the next state is DONE.
- DONE (1 cycle): done=1, busy=1. Next state IDLE.
- cnt_cen, cnt_ld and mem_cs are 0 in every state and cycle not listed above.
- Mismatch handling:
  - First mismatch: fail=1, fail_addr=addr_q (counter has not stepped yet), fail_elem=elem.
  - Later mismatches leave all three unchanged.
  - The test always runs to completion; there is no abort.
  - fail, fail_addr and fail_elem hold after DONE until the next start is accepted.
- Timing:
  - Cycle count: 6 LOAD + N (M0) + 10N (M1-M5) = 11N+6 cycles.
  - The cycle after start is sampled is cycle 1. done is high in cycle 11N+7. busy is high in cycles 1..11N+7.
  - done and busy fall together, on the edge that returns the FSM to IDLE.
- start while busy: ignored. start held high: a new test starts on the cycle after DONE (first IDLE sample).
- rst_n asserted mid-test: immediate IDLE, outputs 0, memory strobes low. The counter is not reset by this block; the next LOAD re-initialises it.

Decomposition:
- Package mbist_pkg holds:
  - state_t enum
  - march_elem_t packed struct {dir_up, has_rd, rd_val, has_wr, wr_val}
  - NUM_ELEM = 6
  - MARCH_CM constant array of march_elem_t
- No sub-module. The address counter is instantiated alongside this block in the MBIST top level, not inside it.

Test Plan (ADDR_W=2, N=4, DATA_W=8, behavioural 1-cycle-latency SRAM plus real counter):
1. Fault-free memory, 1-cycle start pulse -> done=1 exactly in cycle 51, busy high in cycles 1-51, fail=0. The memory ends all-zeros.
2. Bit0 stuck-at-1 at address 2 -> fail=1 at the M1 read of address 2; fail_addr=2, fail_elem=1; done still in cycle 51.
3. Bit7 stuck-at-0 at address 3 -> first mismatch in M2 at address 3: fail_elem=2, fail_addr=3. Later M4 mismatches do not overwrite the capture.
4. Address trace in M3 -> LOAD drives cnt_d_in=3, cnt_ud=0. Addresses read are 3,2,1,0, with cnt_cen=0 in the CMP at address 0.
5. rst_n low for 2 cycles at cycle 20 -> all outputs 0 while low. After release, a new start completes with done in cycle 51 and fail=0.
6. start toggled at cycles 5 and 30 during a run -> ignored, single done in cycle 51. Second test after a fail run -> fail clears on start acceptance.
